// File: rtl/bgr_startup_ctrl.sv
// rtl/bgr_startup_ctrl.sv - Bandgap reference start-up sequencer
//
// Kicks the bandgap with a porst pulse, watches the synchronized vbg, qualifies
// it as stable, and reports ready or fault. Failed attempts are retried up to
// MAX_RETRIES times before the sequencer gives up.
//
// Ports:
//   vdd, gnd   inout   power pins, only present under USE_POWER_PINS
//   wb_clk_i   in  1   clock
//   wb_rst_i   in  1   asynchronous active-high reset
//   en         in  1   sequence enable, synchronous level
//   vbg        in  1   bandgap output, asynchronous (2-flop synchronized)
//   porst      out 1   bandgap start-up kick, high only in PULSE
//   bgr_ok     out 1   reference qualified and stable, high only in READY
//   bgr_fault  out 1   sticky start-up/brownout failure, high only in FAULT
//   retries    out 2   retries consumed in the current sequence
//   state      out 3   FSM state for debug
module bgr_startup_ctrl #(
  parameter int PULSE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SETTLE_CYCLES  = 8,
  parameter int MAX_RETRIES    = 3
) (
`ifdef USE_POWER_PINS
  inout  wire        vdd,
  inout  wire        gnd,
`endif
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       en,
  input  logic       vbg,
  output logic       porst,
  output logic       bgr_ok,
  output logic       bgr_fault,
  output logic [1:0] retries,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_READY  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // One shared counter, wide enough for the longest of the three intervals.
  localparam int MAX_AB  = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  logic             r_vbg_meta;
  logic             r_vbg_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retries;
  logic             r_porst;
  logic             r_bgr_ok;
  logic             r_bgr_fault;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [1:0]       w_next_retries;
  logic             w_fail;

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_retries = r_retries;
    w_fail         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next_cnt     = '0;
        w_next_retries = '0;
        if (en) begin
          w_next_state = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_next_state = S_WAIT;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // vbg may already be high on entry; that simply settles at once.
        if (r_vbg_s) begin
          w_next_state = S_SETTLE;
          w_next_cnt   = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_fail = 1'b1;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (!r_vbg_s) begin
          w_fail = 1'b1;
        end else if (r_cnt == SETTLE_LAST) begin
          w_next_state = S_READY;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (!r_vbg_s) begin
          w_next_state = S_FAULT;
        end
      end
      S_FAULT: begin
        // Held until en drops; no automatic recovery.
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase

    // A failed attempt re-enters PULSE, so every retry gives a fresh porst edge.
    if (w_fail) begin
      w_next_cnt = '0;
      if (r_retries < RETRY_MAX) begin
        w_next_retries = r_retries + 2'd1;
        w_next_state   = S_PULSE;
      end else begin
        w_next_state = S_FAULT;
      end
    end

    // Dropping en overrides every other transition.
    if (!en) begin
      w_next_state   = S_IDLE;
      w_next_cnt     = '0;
      w_next_retries = '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_vbg_meta  <= 1'b0;
      r_vbg_s     <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_porst     <= 1'b0;
      r_bgr_ok    <= 1'b0;
      r_bgr_fault <= 1'b0;
    end else begin
      r_vbg_meta  <= vbg;
      r_vbg_s     <= r_vbg_meta;
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_retries   <= w_next_retries;
      // Outputs are decoded from the next state so they change with the state.
      r_porst     <= (w_next_state == S_PULSE);
      r_bgr_ok    <= (w_next_state == S_READY);
      r_bgr_fault <= (w_next_state == S_FAULT);
    end
  end

  assign porst     = r_porst;
  assign bgr_ok    = r_bgr_ok;
  assign bgr_fault = r_bgr_fault;
  assign retries   = r_retries;
  assign state     = r_state;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// tb/tb_bgr_startup_ctrl.sv - Self-checking bench for bgr_startup_ctrl
`timescale 1ns/100ps
module tb_bgr_startup_ctrl;

  localparam int PULSE_CYCLES   = 16;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int SETTLE_CYCLES  = 8;
  localparam int MAX_RETRIES    = 3;
  localparam int BG_DELAY       = 20;   // 500 ns bandgap rise at a 25 ns clock

  localparam int PH_IDLE   = 0;
  localparam int PH_PULSE  = 1;
  localparam int PH_WAIT   = 2;
  localparam int PH_SETTLE = 3;
  localparam int PH_READY  = 4;
  localparam int PH_FAULT  = 5;

  localparam int BG_DEAD   = 0;
  localparam int BG_NORMAL = 1;
  localparam int BG_LATE   = 2;
  localparam int BG_GLITCH = 3;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       en       = 1'b0;
  logic       vbg      = 1'b0;
  logic       porst;
  logic       bgr_ok;
  logic       bgr_fault;
  logic [1:0] retries;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: phase, cycles spent in phase, retries, synchronizer pipe
  int   m_ph  = PH_IDLE;
  int   m_age = 0;
  int   m_ret = 0;
  logic m_s1  = 1'b0;
  logic m_s2  = 1'b0;

  // bandgap behavioural model
  int   bg_mode  = BG_DEAD;
  int   bg_rise  = 0;
  int   bg_timer = 0;
  logic bg_prev  = 1'b0;

  typedef struct {
    logic en;
    logic vbg;
    int   n;
    int   st;
    int   porst;
    int   ok;
    int   fault;
    int   ret;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  always #12.5 wb_clk_i = ~wb_clk_i;

  bgr_startup_ctrl #(
    .PULSE_CYCLES  (PULSE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .en       (en),
    .vbg      (vbg),
    .porst    (porst),
    .bgr_ok   (bgr_ok),
    .bgr_fault(bgr_fault),
    .retries  (retries),
    .state    (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph  = PH_IDLE;
    m_age = 0;
    m_ret = 0;
    m_s1  = 1'b0;
    m_s2  = 1'b0;
  endtask

  task automatic model_enter(input int ph);
    m_ph  = ph;
    m_age = 0;
  endtask

  task automatic model_attempt_failed();
    if (m_ret < MAX_RETRIES) begin
      m_ret++;
      model_enter(PH_PULSE);
    end else begin
      model_enter(PH_FAULT);
    end
  endtask

  // One clock edge of the sequencer rules; m_age = cycles completed in the phase.
  task automatic model_edge(input logic en_v, input logic vbg_v);
    logic seen;
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = vbg_v;
    if (!en_v) begin
      model_enter(PH_IDLE);
      m_ret = 0;
      return;
    end
    m_age++;
    case (m_ph)
      PH_IDLE:   model_enter(PH_PULSE);
      PH_PULSE:  if (m_age == PULSE_CYCLES) model_enter(PH_WAIT);
      PH_WAIT: begin
        if (seen) model_enter(PH_SETTLE);
        else if (m_age == TIMEOUT_CYCLES) model_attempt_failed();
      end
      PH_SETTLE: begin
        if (!seen) model_attempt_failed();
        else if (m_age == SETTLE_CYCLES) model_enter(PH_READY);
      end
      PH_READY:  if (!seen) model_enter(PH_FAULT);
      default: ;
    endcase
  endtask

  task automatic check_model();
    chk("model_state", int'(state), m_ph);
    chk("model_porst", int'(porst), int'(m_ph == PH_PULSE));
    chk("model_bgr_ok", int'(bgr_ok), int'(m_ph == PH_READY));
    chk("model_bgr_fault", int'(bgr_fault), int'(m_ph == PH_FAULT));
    chk("model_retries", int'(retries), m_ret);
  endtask

  function automatic logic bg_vbg();
    logic up;
    up = (bg_rise > 0) && (bg_timer >= BG_DELAY);
    case (bg_mode)
      BG_DEAD:   return 1'b0;
      BG_LATE:   return up && (bg_rise >= 2);
      BG_GLITCH: return up && !(bg_rise == 1 && (bg_timer == 25 || bg_timer == 26));
      default:   return up;
    endcase
  endfunction

  task automatic bg_update();
    if (porst && !bg_prev) begin
      bg_rise++;
      bg_timer = 0;
    end else if (bg_timer < 100000) begin
      bg_timer++;
    end
    bg_prev = porst;
  endtask

  task automatic tick(input logic en_v, input logic vbg_v);
    @(negedge wb_clk_i);
    en  = en_v;
    vbg = vbg_v;
    @(posedge wb_clk_i);
    model_edge(en_v, vbg_v);
    #1;
    check_model();
    bg_update();
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    #3;
    wb_rst_i = 1'b1;
    en       = 1'b0;
    vbg      = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_porst", int'(porst), 0);
    chk("rst_bgr_ok", int'(bgr_ok), 0);
    chk("rst_bgr_fault", int'(bgr_fault), 0);
    chk("rst_retries", int'(retries), 0);
    model_reset();
    bg_mode  = BG_DEAD;
    bg_rise  = 0;
    bg_timer = 0;
    bg_prev  = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ok_at;
    int   fault_at;
    int   porst_hi;
    int   gap;
    logic prev_p;
    logic rv;

    //            en    vbg  n   st porst ok fault ret
    vecs[0]  = '{1'b0, 1'b1, 2,  0, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1,  1, 1, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 15, 1, 1, 0, 0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1,  2, 0, 0, 0, 0};
    vecs[4]  = '{1'b1, 1'b1, 1,  3, 0, 0, 0, 0};
    vecs[5]  = '{1'b1, 1'b1, 7,  3, 0, 0, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1,  4, 0, 1, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 2,  4, 0, 1, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 1,  5, 0, 0, 1, 0};
    vecs[9]  = '{1'b1, 1'b1, 5,  5, 0, 0, 1, 0};
    vecs[10] = '{1'b0, 1'b0, 1,  0, 0, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1,  1, 1, 0, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1,  0, 0, 0, 0, 0};

    do_reset();

    for (int i = 0; i < NV; i++) begin
      for (int c = 0; c < vecs[i].n; c++) tick(vecs[i].en, vecs[i].vbg);
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      chk($sformatf("vec%0d_porst", i), int'(porst), vecs[i].porst);
      chk($sformatf("vec%0d_bgr_ok", i), int'(bgr_ok), vecs[i].ok);
      chk($sformatf("vec%0d_bgr_fault", i), int'(bgr_fault), vecs[i].fault);
      chk($sformatf("vec%0d_retries", i), int'(retries), vecs[i].ret);
    end

    // Nominal start: tick 1 is the edge that first samples en=1.
    do_reset();
    bg_mode  = BG_NORMAL;
    ok_at    = 0;
    porst_hi = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(1'b1, bg_vbg());
      if (porst) porst_hi++;
      if (bgr_ok) begin
        ok_at = i;
        break;
      end
    end
    chk("nom_porst_cycles", porst_hi, PULSE_CYCLES);
    chk("nom_ok_edge", ok_at, 1 + BG_DELAY + 2 + 1 + SETTLE_CYCLES);
    chk("nom_retries", int'(retries), 0);
    chk("nom_fault", int'(bgr_fault), 0);

    // Brownout: 2 edges to propagate through the synchronizer, 1 to react.
    bg_mode  = BG_DEAD;
    fault_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, bg_vbg());
      if (bgr_fault) begin
        fault_at = i;
        break;
      end
    end
    chk("brown_fault_edge", fault_at, 3);
    chk("brown_ok_low", int'(bgr_ok), 0);
    tick(1'b0, 1'b0);
    chk("rearm_idle", int'(state), PH_IDLE);
    chk("rearm_retries", int'(retries), 0);
    tick(1'b1, 1'b0);
    chk("rearm_porst", int'(porst), 1);

    // Dead bandgap: four pulses, each gap a full timeout, then sticky fault.
    do_reset();
    bg_mode = BG_DEAD;
    prev_p  = 1'b0;
    gap     = 0;
    for (int i = 0; i < 600; i++) begin
      tick(1'b1, bg_vbg());
      if (porst && !prev_p) begin
        if (bg_rise > 1) chk("dead_gap", gap, TIMEOUT_CYCLES);
        gap = 0;
      end
      if (!porst) gap++;
      prev_p = porst;
      if (bgr_fault) break;
    end
    chk("dead_pulses", bg_rise, MAX_RETRIES + 1);
    chk("dead_retries", int'(retries), MAX_RETRIES);
    chk("dead_fault", int'(bgr_fault), 1);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    chk("dead_hold_state", int'(state), PH_FAULT);

    // Late start and settle glitch both need exactly one retry.
    for (int mode = BG_LATE; mode <= BG_GLITCH; mode++) begin
      do_reset();
      bg_mode = mode;
      for (int i = 0; i < 400; i++) begin
        tick(1'b1, bg_vbg());
        if (bgr_ok) break;
      end
      chk($sformatf("retry%0d_ok", mode), int'(bgr_ok), 1);
      chk($sformatf("retry%0d_retries", mode), int'(retries), 1);
      chk($sformatf("retry%0d_fault", mode), int'(bgr_fault), 0);
      chk($sformatf("retry%0d_pulses", mode), bg_rise, 2);
    end

    // Reset mid-PULSE must clear outputs without a clock edge.
    do_reset();
    bg_mode = BG_DEAD;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("mid_in_pulse", int'(porst), 1);
    #5;
    wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_porst", int'(porst), 0);
    chk("mid_rst_state", int'(state), PH_IDLE);
    model_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tick(1'b1, 1'b0);
    chk("mid_restart_state", int'(state), PH_PULSE);

    // Randomized run against the reference model.
    do_reset();
    rv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rv = ~rv;
      tick(($urandom_range(0, 59) != 0), rv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
